// File: rtl/reg_bank_led.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_led
// Brief   : Multi-bank register file with LED half-word display and auto-scan.
//           Optional macro REG0_ZERO_EN hardwires word 0 of every bank to zero.
// Rev     : 1.0  initial release
// ============================================================================
module reg_bank_led #(
   parameter int SIZE     = 5,
   parameter int LEDSIZE  = 8,
   parameter int CSW      = 2,
   parameter int SCAN_DIV = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [SIZE-1:0]        Address,
   input  logic [CSW-1:0]         CS,
   input  logic                   RW,
   input  logic                   En,
   input  logic                   AB,
   input  logic [2*LEDSIZE-1:0]   Din,
   input  logic                   Scan,
   output logic [LEDSIZE-1:0]     LED,
   output logic [2*LEDSIZE-1:0]   Rdata,
   output logic [SIZE-1:0]        ScanAddr,
   output logic                   Busy
);

   localparam int DEPTH = 2**SIZE;
   localparam int DW    = 2*LEDSIZE;
   localparam int BANKS = 2**CSW;
   localparam int WORDS = BANKS*DEPTH;
   localparam int DIVW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [0:0]      c_idle     = 1'b0;
   localparam logic [0:0]      c_scan     = 1'b1;
   localparam logic [DIVW-1:0] c_div_last = DIVW'(SCAN_DIV-1);
   localparam logic [DIVW-1:0] c_div_one  = DIVW'(1);
   localparam logic [SIZE-1:0] c_addr_one = SIZE'(1);

   logic [DW-1:0]      r_mem [WORDS];
   logic [0:0]         r_state;
   logic [DIVW-1:0]    r_div;
   logic [SIZE-1:0]    r_scanaddr;
   logic [DW-1:0]      r_rdata;
   logic [LEDSIZE-1:0] r_led;
   logic               w_wr_en;
   logic [SIZE-1:0]    w_next_addr;

   function automatic logic [DW-1:0] f_word(input logic [CSW-1:0] bank,
                                            input logic [SIZE-1:0] addr);
`ifdef REG0_ZERO_EN
      if (addr == '0) return '0;
`endif
      return r_mem[{bank, addr}];
   endfunction

`ifdef REG0_ZERO_EN
   assign w_wr_en = En && !RW && (Address != '0);
`else
   assign w_wr_en = En && !RW;
`endif

   assign w_next_addr = r_scanaddr + c_addr_one;

   // Reads use the pre-edge memory contents, so a same-cycle write is not seen.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
         r_state    <= c_idle;
         r_div      <= '0;
         r_scanaddr <= '0;
         r_rdata    <= '0;
         r_led      <= '0;
      end else begin
         if (w_wr_en) r_mem[{CS, Address}] <= Din;
         r_led <= AB ? r_rdata[DW-1:LEDSIZE] : r_rdata[LEDSIZE-1:0];
         case (r_state)
            c_idle: begin
               if (Scan) begin
                  r_state    <= c_scan;
                  r_scanaddr <= '0;
                  r_div      <= '0;
                  r_rdata    <= f_word(CS, '0);
               end else if (En && RW) begin
                  r_rdata <= f_word(CS, Address);
               end
            end
            c_scan: begin
               if (!Scan) begin
                  r_state <= c_idle;
               end else if (r_div == c_div_last) begin
                  r_div      <= '0;
                  r_scanaddr <= w_next_addr;
                  r_rdata    <= f_word(CS, w_next_addr);
               end else begin
                  r_div <= r_div + c_div_one;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign LED      = r_led;
   assign Rdata    = r_rdata;
   assign ScanAddr = r_scanaddr;
   assign Busy     = (r_state == c_scan);

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_led.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bank_led
// Brief   : Directed and random checks of reg_bank_led against a cycle model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reg_bank_led;

   localparam int SCAN_DIV = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [4:0]  Address = '0;
   logic [1:0]  CS = '0;
   logic        RW = 1'b0;
   logic        En = 1'b0;
   logic        AB = 1'b0;
   logic [15:0] Din = '0;
   logic        Scan = 1'b0;
   logic [7:0]  LED;
   logic [15:0] Rdata;
   logic [4:0]  ScanAddr;
   logic        Busy;

   int vectors = 0;
   int fails   = 0;

   // Reference state: plain word array plus elapsed cycles since scan entry.
   logic [15:0] m_mem [4][32];
   logic [15:0] m_rdata;
   logic [7:0]  m_led;
   int          m_addr;
   bit          m_scan;
   int          m_t;

   reg_bank_led #(.SIZE(5), .LEDSIZE(8), .CSW(2), .SCAN_DIV(SCAN_DIV)) dut (
      .Clk(Clk), .Reset(Reset), .Address(Address), .CS(CS), .RW(RW), .En(En),
      .AB(AB), .Din(Din), .Scan(Scan), .LED(LED), .Rdata(Rdata),
      .ScanAddr(ScanAddr), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] rd(input int b, input int a);
`ifdef REG0_ZERO_EN
      if (a == 0) return 16'h0000;
`endif
      return m_mem[b][a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("rdata", 32'(Rdata), 32'(m_rdata));
      chk("led", 32'(LED), 32'(m_led));
      chk("scanaddr", 32'(ScanAddr), 32'(m_addr));
      chk("busy", 32'(Busy), 32'(m_scan));
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 32; a++) m_mem[b][a] = 16'h0000;
      m_rdata = '0; m_led = '0; m_addr = 0; m_scan = 0; m_t = 0;
   endtask

   // One clock: predict from pre-edge inputs/state, then compare after the edge.
   task automatic tick();
      logic [15:0] nrd;
      logic [7:0]  nled;
      nrd  = m_rdata;
      nled = AB ? m_rdata[15:8] : m_rdata[7:0];
      if (m_scan) begin
         if (!Scan) begin
            m_scan = 0;
         end else begin
            m_t++;
            m_addr = (m_t / SCAN_DIV) % 32;
            if (m_t % SCAN_DIV == 0) nrd = rd(int'(CS), m_addr);
         end
      end else if (Scan) begin
         m_scan = 1; m_t = 0; m_addr = 0;
         nrd = rd(int'(CS), 0);
      end else if (En && RW) begin
         nrd = rd(int'(CS), int'(Address));
      end
      if (En && !RW) m_mem[CS][Address] = Din;
`ifdef REG0_ZERO_EN
      m_mem[CS][0] = 16'h0000;
`endif
      m_rdata = nrd;
      m_led   = nled;
      @(posedge Clk);
      #1;
      chk_all();
   endtask

   task automatic set_in(input bit en, input bit rw, input int cs, input int a, input logic [15:0] d);
      En = en; RW = rw; CS = 2'(cs); Address = 5'(a); Din = d;
   endtask

   initial begin
      model_reset();
      #1 Reset = 1'b1;
      #2 chk_all();
      @(posedge Clk); #1 chk_all();
      @(negedge Clk) Reset = 1'b0;

      // Every word reads zero after reset.
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 32; a++) begin
            set_in(1, 1, b, a, 16'h0);
            tick();
         end

      set_in(1, 0, 2, 7, 16'hA55A); tick();
      set_in(1, 1, 2, 7, 16'h0);    AB = 1'b0; tick();
      chk("a55a_rdata", 32'(Rdata), 32'h0000A55A);
      set_in(0, 1, 2, 7, 16'h0);    tick();
      chk("a55a_led_lo", 32'(LED), 32'h5A);
      AB = 1'b1; tick();
      chk("a55a_led_hi", 32'(LED), 32'hA5);
      set_in(1, 1, 1, 7, 16'h0); tick();
      chk("cs1_addr7", 32'(Rdata), 32'h0);
      AB = 1'b0;

      for (int a = 0; a < 32; a++) begin
         set_in(1, 0, 1, a, 16'(16'h100 + a));
         tick();
      end
      set_in(0, 0, 1, 0, 16'h0);
      Scan = 1'b1; tick();
      for (int k = 0; k < 20; k++) tick();
      chk("scan_at5", 32'(ScanAddr), 32'd5);
      set_in(1, 0, 1, 5, 16'hBEEF); tick();
      chk("beef_held", 32'(Rdata), 32'h105);
      for (int k = 0; k < 127; k++) begin
         if (k == 10) set_in(1, 1, 1, 20, 16'h0);
         else         set_in(0, 0, 1, 0, 16'h0);
         tick();
      end
      chk("beef_wrap_addr", 32'(ScanAddr), 32'd5);
      chk("beef_wrap", 32'(Rdata), 32'hBEEF);
      Scan = 1'b0; tick();
      chk("busy_drop", 32'(Busy), 32'd0);

      // Reset in the middle of a scan with a pending write.
      Scan = 1'b1; tick();
      for (int k = 0; k < 52; k++) tick();
      chk("scan_at13", 32'(ScanAddr), 32'd13);
      set_in(1, 0, 1, 3, 16'hFFFF);
      Reset = 1'b1; model_reset();
      #1 chk_all();
      @(posedge Clk); #1 chk_all();
      @(negedge Clk) Reset = 1'b0;
      Scan = 1'b0;
      set_in(1, 1, 1, 3, 16'h0); tick();
      chk("addr3_after_rst", 32'(Rdata), 32'h0);

      set_in(1, 0, 0, 0, 16'h1234); tick();
      set_in(1, 1, 0, 0, 16'h0);    tick();
`ifdef REG0_ZERO_EN
      chk("reg0", 32'(Rdata), 32'h0);
`else
      chk("reg0", 32'(Rdata), 32'h1234);
`endif

      for (int k = 0; k < 400; k++) begin
         set_in(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 16'($urandom));
         AB = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) Scan = ~Scan;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_bank_led.md
Name: reg_bank_led

Overview:
- Parametrised multi-bank register file for the lab board. Successor to the single fixed register block.
- Register address from switches, bank from chip-select, data from switch bank `Din`.
- Registered read data is shown on LEDs, one half at a time selected by `AB`.
- Adds an auto-scan mode that walks the selected bank's contents onto the LEDs.

Parameters:
- SIZE, 5, address width; DEPTH = 2**SIZE words per bank
- LEDSIZE, 8, LED width; word width DW = 2*LEDSIZE
- CSW, 2, chip-select width; BANKS = 2**CSW
- SCAN_DIV, 4, clock cycles each word is displayed in scan mode (>=1)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Address  in  SIZE  word address within bank
- CS  in  CSW  bank select
- RW  in  1  1 = read, 0 = write
- En  in  1  access strobe, sampled each cycle
- AB  in  1  LED half select: 0 = bits [LEDSIZE-1:0], 1 = bits [DW-1:LEDSIZE]
- Din  in  DW  write data
- Scan  in  1  request auto-scan of bank CS
- LED  out  LEDSIZE  displayed half-word, registered
- Rdata  out  DW  last read/scanned word, registered
- ScanAddr  out  SIZE  current scan pointer
- Busy  out  1  high while in SCAN

Behaviour:
- Reset: async, Reset=1 immediately clears all BANKS*DEPTH words, Rdata, LED, ScanAddr, Busy and the divider, and forces IDLE. Reset mid-scan or mid-access aborts it; no write completes in a cycle where Reset is high.
- Write: En=1, RW=0 at an edge -> mem[CS][Address] <= Din. Writes are accepted in every state.
- Read (IDLE only):
  - En=1, RW=1 at edge N -> Rdata = mem[CS][Address] after edge N; 1-cycle latency.
  - Read-before-write: a read and a write to the same word in the same cycle cannot occur, since RW is exclusive.
- LED is combinational from registered Rdata and AB, then registered: LED reflects AB one cycle after AB changes.
- Rdata holds its value until the next read or scan update.
- FSM states IDLE, SCAN:
  - IDLE -> SCAN when Scan=1 at an edge. Then ScanAddr=0, divider=0, Busy=1, Rdata=mem[CS][0] (value before any same-cycle write).
  - In SCAN the divider counts 0..SCAN_DIV-1. On terminal count, ScanAddr increments (DEPTH-1 wraps to 0), divider resets, and Rdata loads the new word.
  - A write to the word currently displayed does not update Rdata until the next pointer step or re-entry.
  - CS may change mid-scan; the next step reads from the new bank, and the pointer is kept.
  - SCAN -> IDLE when Scan=0 at an edge. Busy=0 and ScanAddr is held; Rdata keeps the last scanned word.
  - En=1, RW=1 during SCAN is ignored (no queueing).
- All indices are unsigned. Address and CS always select a valid word (power-of-two depth), so no out-of-range case exists.

Optional Feature:
- Macro REG0_ZERO_EN.
- Defined: word 0 of every bank is hardwired to zero; writes to Address=0 are discarded; reads and scans of word 0 return 0.
- Undefined: word 0 is an ordinary storage word.

Test Plan:
- Reset then read every word of banks 0..3 -> Rdata=0, LED=0x00 for each read, 1 cycle after strobe.
- Write Din=0xA55A to CS=2, Address=7; read back with AB=0 then AB=1:
  - Rdata=0xA55A one cycle after the read strobe.
  - LED=0x5A, then 0xA5 one cycle after AB toggles.
  - Same address in CS=1 still reads 0.
- Fill bank 1 with word=addr+0x100 and set Scan=1 with SCAN_DIV=4:
  - ScanAddr steps every 4 cycles and wraps 31->0.
  - Rdata tracks 0x100+ScanAddr; Busy=1.
  - A read strobe during scan leaves Rdata unchanged.
  - Drop Scan -> Busy=0 next edge.
- Assert Reset mid-scan at ScanAddr=13 with pending write of 0xFFFF to addr 3 -> all outputs 0 at once; the word at addr 3 reads 0 after release.
- With REG0_ZERO_EN: write 0x1234 to CS=0, Address=0, then read -> Rdata=0. Without the macro the same sequence gives Rdata=0x1234.
- Write 0xBEEF to the word currently being scanned -> Rdata holds its old value until the next step. After a wrap back to that address, Rdata=0xBEEF.
